// File: rtl/laser_job_sched_if.sv
// laser_job_sched_if: point-stream handshake from one requester into the scheduler
//   valid  producer has a point on x/y
//   ready  scheduler accepts the point this cycle
//   x, y   4-bit point coordinates
interface laser_job_sched_if;
   logic       valid;
   logic       ready;
   logic [3:0] x;
   logic [3:0] y;
   modport master (output valid, x, y, input ready);
   modport slave (input valid, x, y, output ready);
endinterface

// File: rtl/laser_job_sched.sv
// laser_job_sched: round-robin scheduler sharing one LASER engine between two point requesters
//   clk, rst          clock, synchronous active-high reset
//   r0_if, r1_if      requester point streams (valid/ready, 4-bit x/y)
//   core_*            engine reset, replayed points, done pulse and circle result
//   res_*             result handshake tagged with requester id and abort flag
//   busy_o            high whenever the scheduler is not arbitrating
//   LASER_TIMEOUT_EN  when defined, WAIT aborts after TIMEOUT cycles without done
module laser_job_sched #(
   parameter int NPTS = 40
`ifdef LASER_TIMEOUT_EN
   , parameter int TIMEOUT = 100000
`endif
) (
   input  logic             clk,
   input  logic             rst,
   laser_job_sched_if.slave r0_if,
   laser_job_sched_if.slave r1_if,
   output logic             core_rst_o,
   output logic [3:0]       core_x_o,
   output logic [3:0]       core_y_o,
   input  logic             core_done_i,
   input  logic [3:0]       core_c1x_i,
   input  logic [3:0]       core_c1y_i,
   input  logic [3:0]       core_c2x_i,
   input  logic [3:0]       core_c2y_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic             res_id_o,
   output logic [3:0]       res_c1x_o,
   output logic [3:0]       res_c1y_o,
   output logic [3:0]       res_c2x_o,
   output logic [3:0]       res_c2y_o,
   output logic             res_err_o,
   output logic             busy_o
);
   typedef enum logic [2:0] {ARB, FILL, LAUNCH, BURST, WAIT, RESULT} state_t;
   state_t      state_q, state_d;
   logic        last_q, last_d, grant_q, grant_d;
   logic [5:0]  k_q, k_d;
   logic [7:0]  buf_q [NPTS];
   logic        core_rst_q, core_rst_d;
   logic [7:0]  core_xy_q, core_xy_d;
   logic [15:0] res_q, res_d;
   logic        res_id_q, res_id_d;
   logic        sel_valid, last_k;
   logic [7:0]  sel_pt;
`ifdef LASER_TIMEOUT_EN
   logic [16:0] tmo_q, tmo_d;
   logic        err_q, err_d;
`endif
   assign sel_valid = grant_q ? r1_if.valid : r0_if.valid;
   assign sel_pt = grant_q ? {r1_if.x, r1_if.y} : {r0_if.x, r0_if.y};
   assign last_k = k_q == 6'(NPTS - 1);
   assign r0_if.ready = state_q == FILL && !grant_q;
   assign r1_if.ready = state_q == FILL && grant_q;
   always_comb begin
      state_d = state_q;
      last_d = last_q;
      grant_d = grant_q;
      k_d = k_q;
      core_rst_d = 1'b0;
      core_xy_d = '0;
      res_d = res_q;
      res_id_d = res_id_q;
`ifdef LASER_TIMEOUT_EN
      tmo_d = tmo_q;
      err_d = err_q;
`endif
      case (state_q)
         ARB: if (r0_if.valid || r1_if.valid) begin
            grant_d = (r0_if.valid && r1_if.valid) ? !last_q : r1_if.valid;
            last_d = grant_d;
            state_d = FILL;
         end
         FILL: if (sel_valid) begin
            k_d = last_k ? '0 : k_q + 6'd1;
            state_d = last_k ? LAUNCH : FILL;
            core_rst_d = last_k;
         end
         LAUNCH: begin
            // point 0 goes out with the BURST entry, so the replay index starts at 1
            core_xy_d = buf_q[0];
            k_d = 6'd1;
            state_d = BURST;
         end
         BURST: if (k_q == '0) begin
            state_d = WAIT;
`ifdef LASER_TIMEOUT_EN
            tmo_d = '0;
`endif
         end else begin
            core_xy_d = buf_q[k_q];
            k_d = last_k ? '0 : k_q + 6'd1;
         end
         WAIT: begin
            if (core_done_i) begin
               res_d = {core_c1x_i, core_c1y_i, core_c2x_i, core_c2y_i};
               res_id_d = grant_q;
               state_d = RESULT;
`ifdef LASER_TIMEOUT_EN
               err_d = 1'b0;
            end else if (tmo_q == 17'(TIMEOUT - 1)) begin
               res_d = '0;
               res_id_d = grant_q;
               err_d = 1'b1;
               core_rst_d = 1'b1;
               state_d = RESULT;
            end else begin
               tmo_d = tmo_q + 17'd1;
`endif
            end
         end
         RESULT: if (res_ready_i) state_d = ARB;
         default: state_d = ARB;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         last_q <= 1'b1;
         grant_q <= 1'b0;
         k_q <= '0;
         core_rst_q <= 1'b1;
         core_xy_q <= '0;
         res_q <= '0;
         res_id_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         grant_q <= grant_d;
         k_q <= k_d;
         core_rst_q <= core_rst_d;
         core_xy_q <= core_xy_d;
         res_q <= res_d;
         res_id_q <= res_id_d;
      end
   end
   always_ff @(posedge clk) if (state_q == FILL && sel_valid) buf_q[k_q] <= sel_pt;
`ifdef LASER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign res_err_o = err_q;
`else
   assign res_err_o = 1'b0;
`endif
   assign core_rst_o = core_rst_q;
   assign {core_x_o, core_y_o} = core_xy_q;
   assign {res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o} = res_q;
   assign res_id_o = res_id_q;
   assign res_valid_o = state_q == RESULT;
   assign busy_o = state_q != ARB;
endmodule

// File: tb/tb_laser_job_sched.sv
// tb_laser_job_sched: scoreboard bench for laser_job_sched acting as both requesters and the engine
module tb_laser_job_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       core_rst, core_done, res_valid, res_ready, res_id, res_err, busy;
   logic [3:0] core_x, core_y, c1x, c1y, c2x, c2y, r_c1x, r_c1y, r_c2x, r_c2y;
   logic [17:0] got;
   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];
   logic [7:0]  exp_pts [$];
   logic [17:0] res_q [$];
   int nvec = 0, nerr = 0, owner = 0, sent1 = 0, gap_at1 = -1, gap1 = 0;
   bit hs0, hs1;
   always #5 clk = ~clk;
   laser_job_sched_if r0 ();
   laser_job_sched_if r1 ();
   laser_job_sched #(.NPTS(40)
`ifdef LASER_TIMEOUT_EN
      , .TIMEOUT(200)
`endif
   ) dut (
      .clk(clk), .rst(rst), .r0_if(r0), .r1_if(r1),
      .core_rst_o(core_rst), .core_x_o(core_x), .core_y_o(core_y), .core_done_i(core_done),
      .core_c1x_i(c1x), .core_c1y_i(c1y), .core_c2x_i(c2x), .core_c2y_i(c2y),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
      .res_c1x_o(r_c1x), .res_c1y_o(r_c1y), .res_c2x_o(r_c2x), .res_c2y_o(r_c2y),
      .res_err_o(res_err), .busy_o(busy)
   );
   assign got = {res_id, r_c1x, r_c1y, r_c2x, r_c2y, res_err};
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // requester models: handshakes sampled mid-cycle, queues advanced after the edge
   initial begin
      r0.valid = 1'b0; r0.x = '0; r0.y = '0;
      r1.valid = 1'b0; r1.x = '0; r1.y = '0;
      forever begin
         @(negedge clk);
         hs0 = (r0.valid && r0.ready) === 1'b1;
         hs1 = (r1.valid && r1.ready) === 1'b1;
         if (r0.ready === 1'b1 || r1.ready === 1'b1) begin
            nvec++;
            if ((r0.ready === 1'b1 && owner != 0) || (r1.ready === 1'b1 && owner != 1)) begin
               nerr++;
               $display("FAIL ready_owner: r0.ready=%b r1.ready=%b, only requester %0d may be ready", r0.ready, r1.ready, owner);
            end
         end
         @(posedge clk);
         #1;
         if (hs0 && q0.size() > 0) q0.delete(0);
         if (hs1 && q1.size() > 0) begin
            q1.delete(0);
            sent1++;
            if (sent1 == gap_at1) gap1 = 5;
         end
         r0.valid = q0.size() > 0;
         r1.valid = gap1 == 0 && q1.size() > 0;
         if (gap1 > 0) gap1--;
         if (q0.size() > 0) {r0.x, r0.y} = q0[0];
         if (q1.size() > 0) {r1.x, r1.y} = q1[0];
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end
   task automatic add_job(input int req);
      logic [7:0] p;
      for (int i = 0; i < 40; i++) begin
         p = 8'($urandom);
         if (req == 0) q0.push_back(p); else q1.push_back(p);
         exp_pts.push_back(p);
      end
   endtask
   task automatic launch_burst(input int id, input bit spur, input int nb);
      int n;
      logic [7:0] e;
      owner = id;
      n = 0;
      while (!(core_rst === 1'b1 && busy === 1'b1) && n < 400) begin
         tick;
         n++;
      end
      nvec++;
      if (!(core_rst === 1'b1 && busy === 1'b1)) begin
         nerr++;
         $display("FAIL launch: core_rst=%b busy=%b after %0d cycles, required 1/1", core_rst, busy, n);
      end
      for (int j = 0; j < nb; j++) begin
         tick;
         core_done = 1'b0;
         e = exp_pts.size() > 0 ? exp_pts.pop_front() : 8'hxx;
         nvec++;
         if (core_rst !== 1'b0 || {core_x, core_y} !== e) begin
            nerr++;
            $display("FAIL burst[%0d]: core_rst=%b xy=%h, required 0 %h", j, core_rst, {core_x, core_y}, e);
         end
         if (spur && j == 10) begin
            core_done = 1'b1;
            {c1x, c1y, c2x, c2y} = 16'hffff;
         end
      end
   endtask
   task automatic engine_done(input logic id, input logic [15:0] c, input int delay);
      tick;
      nvec++;
      if ({core_x, core_y} !== 8'h00 || core_rst !== 1'b0 || res_valid !== 1'b0) begin
         nerr++;
         $display("FAIL wait_idle: xy=%h core_rst=%b res_valid=%b, required 00 0 0", {core_x, core_y}, core_rst, res_valid);
      end
      repeat (delay) tick;
      core_done = 1'b1;
      {c1x, c1y, c2x, c2y} = c;
      res_q.push_back({id, c, 1'b0});
      tick;
      core_done = 1'b0;
      {c1x, c1y, c2x, c2y} = 16'h0;
   endtask
   task automatic finish_result(input int hold);
      logic [17:0] e;
      e = res_q.size() > 0 ? res_q.pop_front() : 18'hxxxxx;
      nvec++;
      if (res_valid !== 1'b1 || got !== e) begin
         nerr++;
         $display("FAIL result: valid=%b fields=%h, required 1 %h", res_valid, got, e);
      end
      for (int i = 0; i < hold; i++) begin
         tick;
         nvec++;
         if (res_valid !== 1'b1 || got !== e || r0.ready !== 1'b0 || r1.ready !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL result_hold[%0d]: valid=%b fields=%h rdy=%b%b busy=%b, required 1 %h 00 1", i, res_valid, got, r0.ready, r1.ready, busy, e);
         end
      end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      nvec++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL result_release: valid=%b busy=%b, required 0 0", res_valid, busy);
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      exp_pts.delete();
      res_q.delete();
      core_done = 1'b0;
      res_ready = 1'b0;
      tick;
      nvec++;
      if ({r0.ready, r1.ready, core_rst, core_x, core_y, res_valid, got, busy} !== {2'b00, 1'b1, 8'h00, 1'b0, 18'h0, 1'b0}) begin
         nerr++;
         $display("FAIL reset_values: rdy=%b%b core_rst=%b xy=%h res_valid=%b res=%h busy=%b, required 00 1 00 0 00000 0",
                  r0.ready, r1.ready, core_rst, {core_x, core_y}, res_valid, got, busy);
      end
      tick;
      rst = 1'b0;
      tick;
      nvec++;
      if (core_rst !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL reset_release: core_rst=%b busy=%b, required 0 0", core_rst, busy);
      end
   endtask
   task automatic test_single;
      add_job(0);
      launch_burst(0, 1'b0, 40);
      engine_done(1'b0, 16'h34ac, 5);
      finish_result(0);
   endtask
   task automatic test_fairness;
      test_reset;
      add_job(0);
      add_job(1);
      add_job(0);
      add_job(1);
      for (int i = 0; i < 4; i++) begin
         launch_burst(i % 2, 1'b0, 40);
         engine_done(1'(i % 2), 16'(i * 16'h1111 + 16'h0123), 3 + i);
         finish_result(0);
      end
   endtask
   task automatic test_stall;
      sent1 = 0;
      gap_at1 = 18;
      add_job(1);
      launch_burst(1, 1'b0, 40);
      gap_at1 = -1;
      engine_done(1'b1, 16'h5a5a, 2);
      finish_result(0);
   endtask
   task automatic test_result_hold;
      add_job(0);
      add_job(0);
      launch_burst(0, 1'b0, 40);
      engine_done(1'b0, 16'h9876, 1);
      finish_result(20);
      launch_burst(0, 1'b0, 40);
      engine_done(1'b0, 16'h0f1e, 0);
      finish_result(0);
   endtask
   task automatic test_spurious_done;
      add_job(1);
      launch_burst(1, 1'b1, 40);
      engine_done(1'b1, 16'h2468, 4);
      finish_result(0);
   endtask
`ifdef LASER_TIMEOUT_EN
   task automatic test_timeout;
      add_job(0);
      launch_burst(0, 1'b0, 40);
      for (int i = 0; i < 200; i++) begin
         tick;
         nvec++;
         if (res_valid !== 1'b0 || core_rst !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_wait[%0d]: res_valid=%b core_rst=%b, required 0 0", i, res_valid, core_rst);
         end
      end
      tick;
      nvec++;
      if (core_rst !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_core_rst: core_rst=%b, required 1", core_rst);
      end
      res_q.push_back({1'b0, 16'h0, 1'b1});
      finish_result(1);
      nvec++;
      if (core_rst !== 1'b0) begin
         nerr++;
         $display("FAIL timeout_core_rst_pulse: core_rst=%b, required 0", core_rst);
      end
   endtask
`endif
   task automatic test_reset_mid_burst;
      add_job(0);
      launch_burst(0, 1'b0, 10);
      test_reset;
      for (int i = 0; i < 30; i++) begin
         tick;
         nvec++;
         if (res_valid !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b0) begin
            nerr++;
            $display("FAIL dropped_job[%0d]: res_valid=%b busy=%b core_rst=%b, required 0 0 0", i, res_valid, busy, core_rst);
         end
      end
   endtask
   initial begin
      core_done = 1'b0;
      res_ready = 1'b0;
      {c1x, c1y, c2x, c2y} = 16'h0;
      test_reset;
      test_single;
      test_fairness;
      test_stall;
      test_result_hold;
      test_spurious_done;
`ifdef LASER_TIMEOUT_EN
      test_timeout;
`endif
      test_reset_mid_burst;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
